// File: rtl/exc_commit.sv
// Commit-stage exception/interrupt/ERET arbiter with CP0 update pulses and fetch redirect handshake.
// Optional EXC_INT_VECTOR_EN: interrupts vector to offset 0x200 when cause_iv=1 and sr_bev=0.
module exc_commit (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [9:0]  m_exc,
  input  logic        m_store,
  input  logic [31:0] m_daddr,
  input  logic        m_eret,
  input  logic        allow_int,
  input  logic        sr_exl,
  input  logic        sr_bev,
  input  logic        cause_iv,
  input  logic [7:0]  interrupt_flag,
  input  logic [31:0] ebase,
  input  logic [31:0] epc,
  output logic        en_exp_o,
  output logic        exp_bd_o,
  output logic        exp_badvaddr_we_o,
  output logic        clear_exl_o,
  output logic [31:0] exp_epc_o,
  output logic [31:0] exp_badvaddr_o,
  output logic [4:0]  exc_code_o,
  output logic        flush_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] REDIR = 1'b1;

  logic [0:0]  state;
  logic        is_int;
  logic        exc_any;
  logic        take_exc;
  logic        take_eret;
  logic [4:0]  code_n;
  logic        bva_we_n;
  logic [31:0] bva_n;
  logic        tlb_refill;
  logic [31:0] vec_base;
  logic [31:0] vec_off;
  logic        int_vectored;

  assign is_int    = allow_int & (|interrupt_flag);
  assign exc_any   = is_int | (|m_exc);
  assign take_exc  = (state == IDLE) & m_valid & exc_any;
  assign take_eret = (state == IDLE) & m_valid & m_eret & ~exc_any;

`ifdef EXC_INT_VECTOR_EN
  assign int_vectored = cause_iv & ~sr_bev;
`else
  logic cause_iv_unused;
  assign cause_iv_unused = cause_iv;
  assign int_vectored    = 1'b0;
`endif

  // Highest-priority source decides code and bad address; interrupt beats every m_exc bit.
  always_comb begin
    code_n     = 5'd0;
    bva_we_n   = 1'b0;
    bva_n      = 32'h0;
    tlb_refill = 1'b0;
    if (is_int) begin
      code_n = 5'd0;
    end else if (m_exc[0]) begin
      code_n = 5'd4;  bva_we_n = 1'b1; bva_n = m_pc;
    end else if (m_exc[1]) begin
      code_n = 5'd2;  bva_we_n = 1'b1; bva_n = m_pc; tlb_refill = 1'b1;
    end else if (m_exc[2]) begin
      code_n = 5'd2;  bva_we_n = 1'b1; bva_n = m_pc;
    end else if (m_exc[3]) begin
      code_n = 5'd10;
    end else if (m_exc[4]) begin
      code_n = 5'd12;
    end else if (m_exc[5]) begin
      code_n = 5'd8;
    end else if (m_exc[6]) begin
      code_n = 5'd9;
    end else if (m_exc[7]) begin
      code_n = m_store ? 5'd5 : 5'd4; bva_we_n = 1'b1; bva_n = m_daddr;
    end else if (m_exc[8]) begin
      code_n = m_store ? 5'd3 : 5'd2; bva_we_n = 1'b1; bva_n = m_daddr; tlb_refill = 1'b1;
    end else if (m_exc[9]) begin
      code_n = 5'd1;  bva_we_n = 1'b1; bva_n = m_daddr;
    end
  end

  assign vec_base = sr_bev ? 32'hBFC0_0200 : ebase;

  always_comb begin
    vec_off = 32'h180;
    if (tlb_refill && !sr_exl)
      vec_off = 32'h0;
    else if (is_int && int_vectored)
      vec_off = 32'h200;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      en_exp_o          <= 1'b0;
      clear_exl_o       <= 1'b0;
      exp_badvaddr_we_o <= 1'b0;
      exp_bd_o          <= 1'b0;
      exp_epc_o         <= 32'h0;
      exp_badvaddr_o    <= 32'h0;
      exc_code_o        <= 5'd0;
      redirect_pc       <= 32'h0;
    end else begin
      en_exp_o          <= take_exc;
      clear_exl_o       <= take_eret;
      exp_badvaddr_we_o <= take_exc & bva_we_n;
      if (take_exc) begin
        exp_bd_o       <= m_bd;
        exp_epc_o      <= m_bd ? (m_pc - 32'd4) : m_pc;
        exp_badvaddr_o <= bva_n;
        exc_code_o     <= code_n;
        redirect_pc    <= vec_base + vec_off;
        state          <= REDIR;
      end else if (take_eret) begin
        redirect_pc    <= epc;
        state          <= REDIR;
      end else if (state == REDIR && redirect_ready) begin
        state          <= IDLE;
      end
    end
  end

  assign redirect_valid = (state == REDIR);
  assign flush_o        = (state == REDIR);

endmodule

// File: tb/tb_exc_commit.sv
// Directed plus randomized checks of exc_commit against a rule-level reference model.
module tb_exc_commit;
  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_bd, m_store, m_eret;
  logic [31:0] m_pc, m_daddr, ebase, epc;
  logic [9:0]  m_exc;
  logic        allow_int, sr_exl, sr_bev, cause_iv;
  logic [7:0]  interrupt_flag;
  logic        en_exp_o, exp_bd_o, exp_badvaddr_we_o, clear_exl_o, flush_o;
  logic [31:0] exp_epc_o, exp_badvaddr_o, redirect_pc;
  logic [4:0]  exc_code_o;
  logic        redirect_valid, redirect_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          busy;
  bit          chk_hold;
  bit          chk_rpc;
  bit          e_en, e_clr, e_bvwe, e_bd;
  logic [31:0] e_epc, e_bva, rpc;
  logic [4:0]  e_code;
  int          code_tab [10] = '{4, 2, 2, 10, 12, 8, 9, 4, 2, 1};

  exc_commit dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd), .m_exc(m_exc),
    .m_store(m_store), .m_daddr(m_daddr), .m_eret(m_eret), .allow_int(allow_int),
    .sr_exl(sr_exl), .sr_bev(sr_bev), .cause_iv(cause_iv), .interrupt_flag(interrupt_flag),
    .ebase(ebase), .epc(epc), .en_exp_o(en_exp_o), .exp_bd_o(exp_bd_o),
    .exp_badvaddr_we_o(exp_badvaddr_we_o), .clear_exl_o(clear_exl_o), .exp_epc_o(exp_epc_o),
    .exp_badvaddr_o(exp_badvaddr_o), .exc_code_o(exc_code_o), .flush_o(flush_o),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Predict what the coming rising edge produces from the inputs currently applied.
  task automatic model_step();
    int src;
    logic [31:0] off;
    chk_rpc = 1'b0;
    if (rst) begin
      busy = 0; rpc = 0; e_en = 0; e_clr = 0; e_bvwe = 0; e_bd = 0;
      e_epc = 0; e_bva = 0; e_code = 0; chk_hold = 1; chk_rpc = 1;
      return;
    end
    chk_hold = 0; e_en = 0; e_clr = 0; e_bvwe = 0;
    if (busy) begin
      if (redirect_ready) busy = 0;
      return;
    end
    if (!m_valid) return;
    src = -2;
    if (allow_int && interrupt_flag != 8'h0) src = -1;
    else begin
      for (int i = 9; i >= 0; i--) if (m_exc[i]) src = i;
      if (src == -2 && m_eret) src = 10;
    end
    if (src == 10) begin
      e_clr = 1; rpc = epc; busy = 1;
    end else if (src >= -1) begin
      e_en = 1; e_bd = m_bd; busy = 1; chk_hold = 1;
      e_epc  = m_bd ? m_pc - 32'd4 : m_pc;
      e_code = (src == -1) ? 5'd0 : 5'(code_tab[src]);
      if (src == 7 && m_store) e_code = 5'd5;
      if (src == 8 && m_store) e_code = 5'd3;
      e_bvwe = (src >= 0 && src <= 2) || (src >= 7);
      e_bva  = (src >= 0 && src <= 2) ? m_pc : (src >= 7) ? m_daddr : 32'h0;
      off = 32'h180;
      if ((src == 1 || src == 8) && !sr_exl) off = 32'h0;
`ifdef EXC_INT_VECTOR_EN
      if (src == -1 && cause_iv && !sr_bev) off = 32'h200;
`endif
      rpc = (sr_bev ? 32'hBFC00200 : ebase) + off;
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    chk("en_exp", en_exp_o, e_en);
    chk("clear_exl", clear_exl_o, e_clr);
    chk("bva_we", exp_badvaddr_we_o, e_bvwe);
    chk("redirect_valid", redirect_valid, busy);
    chk("flush", flush_o, busy);
    if (busy || chk_rpc) chk("redirect_pc", redirect_pc, rpc);
    if (chk_hold) begin
      chk("exc_code", exc_code_o, e_code);
      chk("exp_epc", exp_epc_o, e_epc);
      chk("exp_bd", exp_bd_o, e_bd);
      chk("badvaddr", exp_badvaddr_o, e_bva);
    end
  endtask

  task automatic quiet();
    rst = 0; m_valid = 0; m_bd = 0; m_store = 0; m_eret = 0; m_exc = '0;
    m_pc = 32'h0; m_daddr = 32'h0; allow_int = 0; interrupt_flag = 8'h0;
    sr_exl = 0; sr_bev = 0; cause_iv = 0; ebase = 32'h80000000; epc = 32'h0;
    redirect_ready = 1;
  endtask

  initial begin
    logic [31:0] pc_hold;
    quiet();
    rst = 1; m_valid = 1; m_exc = 10'h010;  // event during reset must be discarded
    cycle(); cycle();
    rst = 0; quiet(); cycle();
    chk("reset_idle", {31'h0, redirect_valid}, 32'h0);

    // TLB load miss refill vector
    m_valid = 1; m_exc = 10'h100; m_daddr = 32'h00400010; m_pc = 32'h00401000; redirect_ready = 0;
    cycle();
    chk("r31_code", exc_code_o, 5'd2);
    chk("r31_bva", exp_badvaddr_o, 32'h00400010);
    chk("r31_rpc", redirect_pc, 32'h80000000);
    quiet(); cycle(); cycle();

    // overflow in delay slot
    m_valid = 1; m_exc = 10'h010; m_bd = 1; m_pc = 32'h1000;
    cycle();
    chk("r32_epc", exp_epc_o, 32'h0FFC);
    chk("r32_code", exc_code_o, 5'd12);
    chk("r32_rpc", redirect_pc, 32'h80000180);
    quiet(); cycle(); cycle();

    // interrupt beats Sys
    m_valid = 1; m_exc = 10'h020; allow_int = 1; interrupt_flag = 8'h80; cause_iv = 1;
    cycle();
    chk("r33_code", exc_code_o, 5'd0);
`ifdef EXC_INT_VECTOR_EN
    chk("r33_rpc", redirect_pc, 32'h80000200);
`else
    chk("r33_rpc", redirect_pc, 32'h80000180);
`endif
    quiet(); cycle(); cycle();

    // ERET with slow redirect acceptance
    m_valid = 1; m_eret = 1; epc = 32'h80001234; redirect_ready = 0;
    cycle();
    pc_hold = redirect_pc;
    m_valid = 1; m_eret = 1; epc = 32'h0;
    cycle(); cycle();
    redirect_ready = 1; cycle();
    chk("r34_pc_const", redirect_pc, pc_hold);
    quiet(); cycle(); cycle();

    // reset mid-REDIR, then BEV Sys
    m_valid = 1; m_exc = 10'h008; redirect_ready = 0;
    cycle();
    quiet(); rst = 1; redirect_ready = 0; cycle();
    quiet(); m_valid = 1; m_exc = 10'h020; sr_bev = 1; cycle();
    chk("r35_bev", redirect_pc, 32'hBFC00380);
    quiet(); cycle(); cycle();

    for (int n = 0; n < 4000; n++) begin
      rst            = ($urandom_range(0, 59) == 0);
      m_valid        = ($urandom_range(0, 9) < 7);
      m_pc           = $urandom;
      m_daddr        = $urandom;
      m_bd           = $urandom_range(0, 1);
      m_store        = $urandom_range(0, 1);
      m_exc          = ($urandom_range(0, 9) < 6) ? 10'h0 :
                       (10'(1 << $urandom_range(0, 9)) | (($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h0));
      m_eret         = ($urandom_range(0, 5) == 0);
      allow_int      = ($urandom_range(0, 3) == 0);
      interrupt_flag = $urandom_range(0, 1) ? 8'($urandom) : 8'h0;
      sr_exl         = $urandom_range(0, 1);
      sr_bev         = ($urandom_range(0, 3) == 0);
      cause_iv       = $urandom_range(0, 1);
      ebase          = {2'b10, 18'($urandom), 12'h0};
      epc            = $urandom;
      redirect_ready = $urandom_range(0, 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have clock input clk (1 bit); all state updates on its rising edge.
REQ-002 SHALL have reset input rst, synchronous, active-high.
REQ-003 m_valid  in  1  commit-stage instruction valid.
REQ-004 m_pc  in  32  commit-stage instruction PC.
REQ-005 m_bd  in  1  instruction sits in a branch delay slot.
REQ-006 m_exc  in  10  exception flags; bit order [0]IF-AdEL [1]IF-TLB-miss [2]IF-TLB-invalid [3]RI [4]Ov [5]Sys [6]Bp [7]D-AdEL/AdES [8]D-TLB-miss/invalid [9]D-Mod.
REQ-007 m_store  in  1  data access is a store (selects AdES/TLBS).
REQ-008 m_daddr  in  32  data virtual address.
REQ-009 m_eret  in  1  instruction is ERET.
REQ-010 allow_int, sr_exl, sr_bev, cause_iv  in  1 each  CP0 status views; interrupt_flag  in  8  pending-and-enabled IP bits; ebase, epc  in  32 each.
REQ-011 en_exp_o, exp_bd_o, exp_badvaddr_we_o, clear_exl_o  out  1 each; exp_epc_o, exp_badvaddr_o  out  32 each; exc_code_o  out  5  CP0 commit interface.
REQ-012 flush_o  out  1  kill all younger pipeline stages.
REQ-013 redirect_valid  out  1, redirect_pc  out  32, redirect_ready  in  1  fetch redirect handshake.

Function
REQ-014 Event taken in cycle N when m_valid=1, state IDLE, and (interrupt: allow_int & |interrupt_flag) or |m_exc or m_eret.
REQ-015 Priority: interrupt > bit0 > bit1 > bit2 > bit3 ... > bit9 > ERET; only highest is committed.
REQ-016 exc_code_o: Int 0, Mod 1, TLBL 2 (bits1,2; bit8 load), TLBS 3 (bit8 store), AdEL 4 (bit0; bit7 load), AdES 5 (bit7 store), Sys 8, Bp 9, RI 10, Ov 12.
REQ-017 exp_epc_o = m_bd ? m_pc-4 (mod 2^32) : m_pc; exp_bd_o = m_bd.
REQ-018 exp_badvaddr_we_o=1 only for bits 0-2 (value m_pc) and bits 7-9 (value m_daddr); else 0 and exp_badvaddr_o=0.
REQ-019 All CP0 outputs registered: single-cycle pulse in N+1 (en_exp_o for exceptions/interrupts, clear_exl_o for ERET, never both).
REQ-020 Vector base = sr_bev ? 32'hBFC00200 : ebase; offset 0x000 for TLB-miss (bits1,8 miss) with sr_exl=0, else 0x180 (interrupt offset per REQ-030); ERET target = epc sampled in cycle N.
REQ-021 FSM states IDLE, REDIR; IDLE->REDIR on taken event; REDIR->IDLE in cycle redirect_valid & redirect_ready.
REQ-022 In REDIR: flush_o=1, redirect_valid=1, redirect_pc stable; m_* inputs ignored.
REQ-023 redirect_valid SHALL NOT drop before redirect_ready; back-to-back events need one IDLE cycle (accepted-cycle inputs ignored).
REQ-024 m_valid=0 suppresses everything, including interrupts.
REQ-025 ERET and any m_exc bit simultaneously: exception wins, no clear_exl_o.

Reset
REQ-026 rst SHALL force state IDLE and all outputs 0 (redirect_pc, exp_* = 32'h0) the following cycle, including mid-REDIR.
REQ-027 Event inputs during the rst cycle SHALL be discarded.

Configuration
REQ-028 Macro EXC_INT_VECTOR_EN selects interrupt vectoring.
REQ-029 Not defined: interrupts use offset 0x180.
REQ-030 Defined: interrupts use offset 0x200 when cause_iv=1 and sr_bev=0, else 0x180.

Verification
REQ-031 ebase=0x80000000, bev=0, exl=0, m_exc[8] load, m_daddr=0x00400010, m_pc=0x00401000 -> N+1 en_exp_o=1, exc_code=2, badvaddr=0x00400010, redirect_pc=0x80000000.
REQ-032 m_exc[4], m_bd=1, m_pc=0x1000 -> epc=0x0FFC, exp_bd=1, code 12, badvaddr_we=0, redirect_pc=ebase+0x180.
REQ-033 interrupt_flag=0x80, allow_int=1, m_exc[5]=1, cause_iv=1 -> code 0; redirect_pc=ebase+0x200 with macro, +0x180 without.
REQ-034 m_eret, epc=0x80001234, redirect_ready low 3 cycles -> clear_exl_o 1-cycle pulse, redirect_valid/flush held 4 cycles, pc constant.
REQ-035 rst asserted while REDIR -> next cycle IDLE, all outputs 0; sr_bev=1 Sys -> redirect_pc=0xBFC00380.
